// File: rtl/mac_accumulator.sv
// Signed fixed-point multiply-accumulate over a burst of N_TERMS pairs.
// Emits one saturated, truncated dot product per burst with a single-cycle out_valid pulse.
module mac_accumulator #(
    parameter int WIDTH   = 32,
    parameter int FRAC    = 16,
    parameter int N_TERMS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam int ACC_W = 2 * WIDTH + 8;
    localparam int CNT_W = $clog2(N_TERMS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FINAL = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic signed [2*WIDTH-1:0] prod_q, prod_d;
    logic                      prod_v_q, prod_v_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]          out_q, out_d;
    logic                      out_valid_q, out_valid_d;
    logic                      accept_s;

    // Clamp a wide signed value into WIDTH bits; it fits when all bits above the result sign agree.
    function automatic logic [WIDTH-1:0] sat_narrow(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-WIDTH:0] upper;
        upper = v[ACC_W-1:WIDTH-1];
        if ((&upper) || (~|upper)) begin
            return v[WIDTH-1:0];
        end else if (v[ACC_W-1]) begin
            return {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end
    endfunction

    assign accept_s  = in_valid && (state_q == ST_ACC);
    assign in_ready  = (state_q == ST_ACC);
    assign busy      = (state_q != ST_IDLE);
    assign out       = out_q;
    assign out_valid = out_valid_q;

    // Next-state, product pipeline, accumulator and result logic.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        prod_d      = prod_q;
        prod_v_d    = 1'b0;
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (prod_v_q) begin
            acc_d = acc_q + {{(ACC_W-2*WIDTH){prod_q[2*WIDTH-1]}}, prod_q};
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACC;
                    count_d = {CNT_W{1'b0}};
                    acc_d   = {ACC_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (accept_s) begin
                    prod_d   = (2*WIDTH)'($signed(a)) * (2*WIDTH)'($signed(b));
                    prod_v_d = 1'b1;
                    count_d  = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (count_q == CNT_W'(N_TERMS - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            // The last product lands in acc on this edge.
            ST_DRAIN: begin
                state_d = ST_FINAL;
            end
            ST_FINAL: begin
                out_d       = sat_narrow(acc_q >>> FRAC);
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= {CNT_W{1'b0}};
            prod_q      <= {(2*WIDTH){1'b0}};
            prod_v_q    <= 1'b0;
            acc_q       <= {ACC_W{1'b0}};
            out_q       <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            prod_q      <= prod_d;
            prod_v_q    <= prod_v_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed burst cases plus randomized bursts
// compared against a wide-integer dot-product reference model.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] out;
    logic        out_valid;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] av [4];
    logic [31:0] bv [4];

    localparam logic signed [79:0] MAXV = 80'sd2147483647;
    localparam logic signed [79:0] MINV = -80'sd2147483648;

    mac_accumulator #(.WIDTH(32), .FRAC(16), .N_TERMS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact dot product in 80-bit integers, floor-divided by 2^16, then clamped.
    function automatic logic [31:0] model_result();
        logic signed [79:0] sum;
        logic signed [79:0] scaled;
        sum = 80'sd0;
        for (int i = 0; i < 4; i++) begin
            sum = sum + 80'($signed(av[i])) * 80'($signed(bv[i]));
        end
        scaled = sum >>> 16;
        if (scaled > MAXV)      return 32'h7FFF_FFFF;
        else if (scaled < MINV) return 32'h8000_0000;
        else                    return scaled[31:0];
    endfunction

    task automatic set_pairs(input logic [31:0] a0, b0, a1, b1, a2, b2, a3, b3);
        av[0] = a0; bv[0] = b0; av[1] = a1; bv[1] = b1;
        av[2] = a2; bv[2] = b2; av[3] = a3; bv[3] = b3;
    endtask

    task automatic run_burst(input int gap, input bit poke, input logic [31:0] exp, input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = poke;
        check({tag, ".ready_acc"}, {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                a = $urandom;
                b = $urandom;
                @(negedge clk);
            end
            in_valid = 1'b1;
            a = av[i];
            b = bv[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        check({tag, ".drain_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, ".drain_busy"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        check({tag, ".final_ov"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check({tag, ".ov_pulse"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".out"}, out, exp);
        check({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({tag, ".ov_clear"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".out_hold"}, out, exp);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset.out", out, 32'd0);
        check("reset.ov", {31'd0, out_valid}, 32'd0);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.ready", {31'd0, in_ready}, 32'd0);

        // in_valid while idle must not start anything.
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("idle_valid.busy", {31'd0, busy}, 32'd0);

        set_pairs(32'h0001_8000, 32'h0002_0000, 32'hFFFF_8000, 32'h0004_0000,
                  32'h0000_4000, 32'h0000_4000, 32'h0001_0000, 32'h0001_0000);
        run_burst(0, 1'b0, 32'h0002_1000, "basic");
        run_burst(3, 1'b0, 32'h0002_1000, "gapped");
        run_burst(1, 1'b1, 32'h0002_1000, "start_busy");

        set_pairs(32'h00C8_0000, 32'h00C8_0000, 32'h00C8_0000, 32'h00C8_0000,
                  32'h00C8_0000, 32'h00C8_0000, 32'h00C8_0000, 32'h00C8_0000);
        run_burst(0, 1'b0, 32'h7FFF_FFFF, "sat_pos");
        set_pairs(32'h00C8_0000, 32'hFF38_0000, 32'h00C8_0000, 32'hFF38_0000,
                  32'h00C8_0000, 32'hFF38_0000, 32'h00C8_0000, 32'hFF38_0000);
        run_burst(0, 1'b0, 32'h8000_0000, "sat_neg");

        set_pairs(32'h0000_0001, 32'h0000_8000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        run_burst(0, 1'b0, 32'h0000_0000, "trunc_pos");
        set_pairs(32'hFFFF_FFFF, 32'h0000_8000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        run_burst(0, 1'b0, 32'hFFFF_FFFF, "trunc_neg");

        // Abort a burst after two accepts.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        a        = 32'h0001_0000;
        b        = 32'h0001_0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("midrst.busy", {31'd0, busy}, 32'd0);
        check("midrst.out", out, 32'd0);
        check("midrst.ready", {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("midrst.no_ov", {31'd0, out_valid}, 32'd0);
        set_pairs(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                  32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        run_burst(0, 1'b0, 32'h0004_0000, "after_rst");

        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    av[i] = $urandom;
                    bv[i] = $urandom;
                end else begin
                    av[i] = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
                    bv[i] = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
                end
            end
            run_burst(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), model_result(), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
